compressor_tree_n_2_pipe: RTL and testbench

// - Pipelined, parametrised N:2 carry-save reduction tree built from compressor_4_2_n_bit levels.
// - Adds a carry-save accumulator so MAC-style partial products can be summed over many beats

---
 rtl/compressor_tree_n_2_pipe.sv | 112 +++++++++++
 tb/tb_compressor_tree_n_2_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/compressor_tree_n_2_pipe.sv
// Pipelined N:2 carry-save reduction tree with a carry-save accumulator stage.
// Valid/ready streaming with a single global stall enable across all stages.
`timescale 1ns/1ps
module compressor_tree_n_2_pipe #(
  parameter int unsigned NUM_IN   = 8,
  parameter int unsigned IN_SIZE  = 12,
  parameter int unsigned OUT_SIZE = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IN_SIZE-1:0]  in_i [NUM_IN],
  input  logic                acc_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [OUT_SIZE-1:0] sum_o,
  output logic [OUT_SIZE-1:0] carry_o,
  output logic                valid_o,
  input  logic                ready_i
);

  localparam int unsigned LVLS  = $clog2(NUM_IN) - 1;
  localparam int unsigned WORDS = NUM_IN / 2;

  logic [OUT_SIZE-1:0] lvl_q [LVLS][WORDS];
  logic [OUT_SIZE-1:0] lvl_d [LVLS][WORDS];
  logic [LVLS-1:0]     vld_q, vld_d;
  logic [LVLS-1:0]     tag_q, tag_d;
  logic [OUT_SIZE-1:0] acc_s_q, acc_s_d;
  logic [OUT_SIZE-1:0] acc_c_q, acc_c_d;
  logic                valid_o_q, valid_o_d;
  logic                en;
  logic [2*OUT_SIZE-1:0] r;

  // Two chained 3:2 stages; returns {carry, sum}, congruent to a+b+c+d mod 2^OUT_SIZE.
  function automatic logic [2*OUT_SIZE-1:0] c42(
    input logic [OUT_SIZE-1:0] a,
    input logic [OUT_SIZE-1:0] b,
    input logic [OUT_SIZE-1:0] c,
    input logic [OUT_SIZE-1:0] d
  );
    logic [OUT_SIZE-1:0] s1, c1, s2, c2;
    s1 = a ^ b ^ c;
    c1 = ((a & b) | (a & c) | (b & c)) << 1;
    s2 = s1 ^ d ^ c1;
    c2 = ((s1 & d) | (s1 & c1) | (d & c1)) << 1;
    return {c2, s2};
  endfunction

  always_comb begin
    en        = ready_i | ~valid_o_q;
    lvl_d     = lvl_q;
    vld_d     = vld_q;
    tag_d     = tag_q;
    acc_s_d   = acc_s_q;
    acc_c_d   = acc_c_q;
    valid_o_d = valid_o_q;
    r         = '0;
    if (en) begin
      for (int unsigned j = 0; j < NUM_IN / 4; j++) begin
        r = c42(OUT_SIZE'(in_i[4*j]),   OUT_SIZE'(in_i[4*j+1]),
                OUT_SIZE'(in_i[4*j+2]), OUT_SIZE'(in_i[4*j+3]));
        lvl_d[0][2*j]   = r[OUT_SIZE-1:0];
        lvl_d[0][2*j+1] = r[2*OUT_SIZE-1:OUT_SIZE];
      end
      vld_d[0] = valid_i;
      tag_d[0] = acc_i;
      for (int unsigned k = 1; k < LVLS; k++) begin
        for (int unsigned j = 0; j < (NUM_IN >> (k + 2)); j++) begin
          r = c42(lvl_q[k-1][4*j],   lvl_q[k-1][4*j+1],
                  lvl_q[k-1][4*j+2], lvl_q[k-1][4*j+3]);
          lvl_d[k][2*j]   = r[OUT_SIZE-1:0];
          lvl_d[k][2*j+1] = r[2*OUT_SIZE-1:OUT_SIZE];
        end
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
      valid_o_d = vld_q[LVLS-1];
      // Bubbles advance but leave the accumulator untouched.
      if (vld_q[LVLS-1]) begin
        r = c42(lvl_q[LVLS-1][0], lvl_q[LVLS-1][1],
                tag_q[LVLS-1] ? acc_s_q : '0,
                tag_q[LVLS-1] ? acc_c_q : '0);
        acc_s_d = r[OUT_SIZE-1:0];
        acc_c_d = r[2*OUT_SIZE-1:OUT_SIZE];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q     <= '{default: '0};
      vld_q     <= '0;
      tag_q     <= '0;
      acc_s_q   <= '0;
      acc_c_q   <= '0;
      valid_o_q <= 1'b0;
    end else begin
      lvl_q     <= lvl_d;
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      acc_s_q   <= acc_s_d;
      acc_c_q   <= acc_c_d;
      valid_o_q <= valid_o_d;
    end
  end

  assign ready_o = en;
  assign sum_o   = acc_s_q;
  assign carry_o = acc_c_q;
  assign valid_o = valid_o_q;

endmodule

// File: tb/tb_compressor_tree_n_2_pipe.sv
// Directed bench: a 24-bit and a 16-bit result instance share one stimulus stream.
`timescale 1ns/1ps
module tb_compressor_tree_n_2_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [11:0] in_w [8];
  logic        acc_i, valid_i, ready_i;
  logic        ready24, ready16, valid24, valid16;
  logic [23:0] sum24, carry24;
  logic [15:0] sum16, carry16;
  int          checks = 0;
  int          failures = 0;

  compressor_tree_n_2_pipe #(.NUM_IN(8), .IN_SIZE(12), .OUT_SIZE(24)) dut24 (
    .clk_i(clk), .rst_i(rst_i), .in_i(in_w), .acc_i(acc_i), .valid_i(valid_i),
    .ready_o(ready24), .sum_o(sum24), .carry_o(carry24), .valid_o(valid24),
    .ready_i(ready_i));

  compressor_tree_n_2_pipe #(.NUM_IN(8), .IN_SIZE(12), .OUT_SIZE(16)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .in_i(in_w), .acc_i(acc_i), .valid_i(valid_i),
    .ready_o(ready16), .sum_o(sum16), .carry_o(carry16), .valid_o(valid16),
    .ready_i(ready_i));

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int tot24();
    return int'(24'(sum24 + carry24));
  endfunction

  function automatic int tot16();
    return int'(16'(sum16 + carry16));
  endfunction

  task automatic set_fill(input logic [11:0] v);
    for (int i = 0; i < 8; i++) in_w[i] = v;
  endtask

  task automatic set_seq();
    for (int i = 0; i < 8; i++) in_w[i] = 12'(i + 1);
  endtask

  initial begin
    int b;
    logic rdy;
    int exp_v [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    int exp_t [9] = '{0, 0, 36, 36, 36, 72, 108, 144, 0};

    rst_i = 1'b1; valid_i = 1'b0; acc_i = 1'b0; ready_i = 1'b1; set_fill(12'h000);
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("rst_valid", int'(valid24), 0);
    chk("rst_sum", int'(sum24), 0);
    chk("rst_carry", int'(carry24), 0);
    chk("rst_ready", int'(ready24), 1);

    // Single all-ones beat: three register stages to the output.
    set_fill(12'hFFF); acc_i = 1'b0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("lat_c1", int'(valid24), 0);
    tick();
    chk("lat_c2", int'(valid24), 0);
    tick();
    chk("lat_c3", int'(valid24), 1);
    chk("ones_sum", tot24(), 32760);
    chk("ones_sum16", tot16(), 32760);
    tick();
    chk("valid_drop", int'(valid24), 0);

    // Back-to-back accumulation.
    for (int t = 0; t < 6; t++) begin
      set_seq();
      valid_i = (t < 4);
      acc_i   = (t != 0);
      tick();
      if (t >= 2) begin
        chk("b2b_valid", int'(valid24), 1);
        chk("b2b_sum", tot24(), 36 * (t - 1));
      end
    end
    valid_i = 1'b0;
    tick();
    chk("b2b_idle", int'(valid24), 0);

    // Downstream stall while the first result is presented.
    b = 0;
    for (int t = 0; t < 9; t++) begin
      ready_i = !(t >= 2 && t <= 4);
      valid_i = (b < 4);
      acc_i   = (b != 0);
      set_seq();
      #1;
      if (t == 3 || t == 4) chk("stall_ready", int'(ready24), 0);
      rdy = ready24;
      tick();
      if (rdy && valid_i) b++;
      chk("stall_valid", int'(valid24), exp_v[t]);
      if (exp_v[t] == 1) chk("stall_sum", tot24(), exp_t[t]);
    end
    chk("stall_beats", b, 4);
    valid_i = 1'b0; ready_i = 1'b1;

    // Bubbles between beats must not disturb the accumulator.
    set_seq(); acc_i = 1'b0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    chk("bub_a_valid", int'(valid24), 1);
    chk("bub_a_sum", tot24(), 36);
    set_fill(12'h001); acc_i = 1'b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("bub_hold_valid", int'(valid24), 0);
    chk("bub_hold_sum", tot24(), 36);
    tick();
    tick();
    chk("bub_b_valid", int'(valid24), 1);
    chk("bub_b_sum", tot24(), 44);

    // Wrap in the narrow instance.
    set_fill(12'hFFF);
    for (int t = 0; t < 5; t++) begin
      valid_i = (t < 3);
      acc_i   = (t != 0);
      tick();
    end
    valid_i = 1'b0;
    chk("wrap_valid", int'(valid16), 1);
    chk("wrap_sum16", tot16(), 32744);
    chk("wrap_sum24", tot24(), 98280);

    // Reset with two beats in flight.
    set_seq(); acc_i = 1'b0; valid_i = 1'b1;
    tick();
    tick();
    valid_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_valid", int'(valid24), 0);
    chk("mid_rst_sum", int'(sum24), 0);
    chk("mid_rst_carry", int'(carry24), 0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("no_stale", int'(valid24), 0);
    end

    // acc_i=1 as first beat after reset behaves as a restart.
    set_seq(); acc_i = 1'b1; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    chk("first_acc_valid", int'(valid24), 1);
    chk("first_acc_sum", tot24(), 36);
    chk("first_acc_sum16", tot16(), 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
